// File: rtl/tdc_event_builder_if.sv
// Event-builder bus: TDC head/tail strobes and coarse time in, event FIFO read side out.
// master drives the strobes and consumer controls; slave is the event builder.
interface tdc_event_builder_if;
    logic [5:0]  head_code;
    logic        head_wr;
    logic [5:0]  tail_code;
    logic        tail_wr;
    logic [11:0] coarse;
    logic        rd_en;
    logic        ovf_clr;
    logic [31:0] evt_data;
    logic        evt_valid;
    logic        fifo_full;
    logic        overflow;

    modport master (
        output head_code, head_wr, tail_code, tail_wr, coarse, rd_en, ovf_clr,
        input  evt_data, evt_valid, fifo_full, overflow
    );

    modport slave (
        input  head_code, head_wr, tail_code, tail_wr, coarse, rd_en, ovf_clr,
        output evt_data, evt_valid, fifo_full, overflow
    );
endinterface

// File: rtl/tdc_event_builder.sv
// Pairs TDC head/tail hits into 32-bit event words in a show-ahead FIFO; TDC_EVB_TIMEOUT_EN adds a tail timeout.
// Word visible 2 cycles after the tail strobe; no backpressure upstream: a full FIFO drops the word and sets sticky overflow.
module tdc_event_builder #(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    tdc_event_builder_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 4 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 4..256");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, WAIT_TAIL, PUSH} state_t;

    state_t      state;
    logic [5:0]  head_q;
    logic [5:0]  tail_q;
    logic [11:0] coarse_q;
    logic [11:0] delta_q;
    logic        tmo_q;
    logic        tmo_hit;

`ifdef TDC_EVB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt;

    // A fresh head restarts the window; leaving WAIT_TAIL clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (state == WAIT_TAIL && !bus.head_wr)
            cnt <= cnt + TW'(1);
        else
            cnt <= '0;
    end

    assign tmo_hit = (cnt == TW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            coarse_q <= '0;
            delta_q  <= '0;
            tmo_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.head_wr) begin
                        head_q   <= bus.head_code;
                        coarse_q <= bus.coarse;
                        tmo_q    <= 1'b0;
                        if (bus.tail_wr) begin
                            tail_q  <= bus.tail_code;
                            delta_q <= '0;
                            state   <= PUSH;
                        end else begin
                            state   <= WAIT_TAIL;
                        end
                    end
                end
                WAIT_TAIL: begin
                    // A tail always wins: it closes the pending head even if a new head arrives with it.
                    if (bus.tail_wr) begin
                        tail_q  <= bus.tail_code;
                        delta_q <= bus.coarse - coarse_q;
                        state   <= PUSH;
                    end else if (bus.head_wr) begin
                        head_q   <= bus.head_code;
                        coarse_q <= bus.coarse;
                    end else if (tmo_hit) begin
                        tail_q  <= '0;
                        delta_q <= '0;
                        tmo_q   <= 1'b1;
                        state   <= PUSH;
                    end
                end
                PUSH:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic [31:0] word;
    assign word = {tmo_q, (head_q == 6'd0), (tail_q == 6'd0) && !tmo_q, 5'd0, delta_q, head_q, tail_q};

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_n;
    logic          valid_q;
    logic          full_q;
    logic          ovf_q;
    logic          push;
    logic          wr_ok;
    logic          pop;
    logic          drop;

    assign push    = (state == PUSH);
    assign pop     = bus.rd_en && valid_q;
    assign wr_ok   = push && (!full_q || bus.rd_en);
    assign drop    = push && !wr_ok;
    assign count_n = count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count   <= count_n;
            valid_q <= (count_n != '0);
            full_q  <= (count_n == (AW+1)'(FIFO_DEPTH));
            if (drop)
                ovf_q <= 1'b1;
            else if (bus.ovf_clr)
                ovf_q <= 1'b0;
        end
    end

    assign bus.evt_data  = valid_q ? mem[rd_ptr] : 32'd0;
    assign bus.evt_valid = valid_q;
    assign bus.fifo_full = full_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_tdc_event_builder.sv
// Directed bench for tdc_event_builder: pairing, wrap, collisions, FIFO full/overflow, timeout, reset.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_tdc_event_builder;
    localparam int DEPTH = 16;
    localparam int TMO   = 1023;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    tdc_event_builder_if bus();

    tdc_event_builder #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic h, input logic [5:0] hc, input logic t,
                          input logic [5:0] tc, input logic [11:0] co);
        bus.head_wr   = h;
        bus.head_code = hc;
        bus.tail_wr   = t;
        bus.tail_code = tc;
        bus.coarse    = co;
        @(negedge clk);
        bus.head_wr = 1'b0;
        bus.tail_wr = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    logic [31:0] exp_q[$];
    logic [5:0]  hc;
    logic [5:0]  tc;

    initial begin
        bus.head_code = '0;
        bus.head_wr   = 1'b0;
        bus.tail_code = '0;
        bus.tail_wr   = 1'b0;
        bus.coarse    = '0;
        bus.rd_en     = 1'b0;
        bus.ovf_clr   = 1'b0;

        tick(2);
        check("rst_valid", {31'd0, bus.evt_valid}, 32'd0);
        check("rst_full",  {31'd0, bus.fifo_full}, 32'd0);
        check("rst_ovf",   {31'd0, bus.overflow},  32'd0);
        check("rst_data",  bus.evt_data, 32'd0);
        rst = 1'b1;
        tick(1);

        // Basic pair: head at coarse 100, tail 7 cycles later at 107.
        strobe(1'b1, 6'h15, 1'b0, 6'h00, 12'd100);
        tick(6);
        strobe(1'b0, 6'h00, 1'b1, 6'h2A, 12'd107);
        check("lat_1cyc_valid", {31'd0, bus.evt_valid}, 32'd0);
        tick(1);
        check("lat_2cyc_valid", {31'd0, bus.evt_valid}, 32'd1);
        check("basic_word", bus.evt_data, 32'h0000_756A);
        pop();
        check("pop_to_empty", {31'd0, bus.evt_valid}, 32'd0);
        pop();
        check("pop_on_empty", {31'd0, bus.evt_valid}, 32'd0);

        // Coarse wrap: (5 - 4090) mod 4096 = 11, and (5 - 4086) mod 4096 = 15.
        strobe(1'b1, 6'h01, 1'b0, 6'h00, 12'd4090);
        tick(2);
        strobe(1'b0, 6'h00, 1'b1, 6'h02, 12'd5);
        tick(1);
        check("wrap_word_b", bus.evt_data, 32'h0000_B042);
        pop();
        strobe(1'b1, 6'h03, 1'b0, 6'h00, 12'd4086);
        tick(1);
        strobe(1'b0, 6'h00, 1'b1, 6'h04, 12'd5);
        tick(1);
        check("wrap_word_f", bus.evt_data, 32'h0000_F0C4);
        pop();

        // Same-cycle head+tail with head collision; a head during PUSH and a lone tail in IDLE are ignored.
        strobe(1'b1, 6'h00, 1'b1, 6'h01, 12'd77);
        strobe(1'b1, 6'h09, 1'b0, 6'h00, 12'd1);
        check("same_cycle_word", bus.evt_data, 32'h4000_0001);
        strobe(1'b0, 6'h00, 1'b1, 6'h05, 12'd3);
        tick(2);
        pop();
        check("push_strobe_ignored", {31'd0, bus.evt_valid}, 32'd0);

        // Second head in WAIT_TAIL replaces the first.
        strobe(1'b1, 6'h11, 1'b0, 6'h00, 12'd10);
        tick(1);
        strobe(1'b1, 6'h22, 1'b0, 6'h00, 12'd20);
        tick(1);
        strobe(1'b0, 6'h00, 1'b1, 6'h33, 12'd25);
        tick(1);
        check("rehead_word", bus.evt_data, 32'h0000_58B3);
        pop();

        // Head+tail in WAIT_TAIL: tail closes pending head, new head is dropped.
        strobe(1'b1, 6'h07, 1'b0, 6'h00, 12'd300);
        tick(1);
        strobe(1'b1, 6'h08, 1'b1, 6'h09, 12'd302);
        tick(1);
        check("wait_both_word", bus.evt_data, 32'h0000_21C9);
        pop();
        strobe(1'b0, 6'h00, 1'b1, 6'h0A, 12'd400);
        tick(2);
        check("wait_both_no_pending", {31'd0, bus.evt_valid}, 32'd0);

        // Fill, overflow, clear, full write+pop, drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            hc = 6'(i + 1);
            tc = 6'(63 - i);
            strobe(1'b1, hc, 1'b1, tc, 12'd0);
            tick(1);
            exp_q.push_back({20'd0, hc, tc});
            if (i == DEPTH - 2)
                check("not_full_15", {31'd0, bus.fifo_full}, 32'd0);
        end
        check("full_16", {31'd0, bus.fifo_full}, 32'd1);
        check("no_ovf_16", {31'd0, bus.overflow}, 32'd0);
        check("head_16", bus.evt_data, exp_q[0]);
        strobe(1'b1, 6'h2C, 1'b1, 6'h2D, 12'd0);
        tick(1);
        check("ovf_17", {31'd0, bus.overflow}, 32'd1);
        check("full_17", {31'd0, bus.fifo_full}, 32'd1);
        strobe(1'b1, 6'h2E, 1'b1, 6'h2F, 12'd0);
        bus.ovf_clr = 1'b1;
        tick(1);
        bus.ovf_clr = 1'b0;
        check("ovf_clr_with_drop", {31'd0, bus.overflow}, 32'd1);
        bus.ovf_clr = 1'b1;
        tick(1);
        bus.ovf_clr = 1'b0;
        check("ovf_clr", {31'd0, bus.overflow}, 32'd0);
        strobe(1'b1, 6'h30, 1'b1, 6'h31, 12'd0);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(32'h0000_0C31);
        check("full_wr_pop_full", {31'd0, bus.fifo_full}, 32'd1);
        check("full_wr_pop_ovf", {31'd0, bus.overflow}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain_%0d", i), bus.evt_data, exp_q[i]);
            pop();
            if (i == 0)
                check("full_after_pop", {31'd0, bus.fifo_full}, 32'd0);
        end
        check("drained", {31'd0, bus.evt_valid}, 32'd0);

        // Lone head, no tail.
        strobe(1'b1, 6'h03, 1'b0, 6'h00, 12'd50);
        tick(TMO);
        check("tmo_not_early", {31'd0, bus.evt_valid}, 32'd0);
        tick(1);
`ifdef TDC_EVB_TIMEOUT_EN
        check("tmo_valid", {31'd0, bus.evt_valid}, 32'd1);
        check("tmo_word", bus.evt_data, 32'h8000_00C0);
        pop();
`else
        check("no_tmo_valid", {31'd0, bus.evt_valid}, 32'd0);
`endif

        // Reset mid-event with a word already queued.
        strobe(1'b1, 6'h01, 1'b1, 6'h02, 12'd0);
        tick(1);
        strobe(1'b1, 6'h12, 1'b0, 6'h00, 12'd5);
        tick(2);
        check("pre_rst_valid", {31'd0, bus.evt_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, bus.evt_valid}, 32'd0);
        check("async_rst_data",  bus.evt_data, 32'd0);
        check("async_rst_full",  {31'd0, bus.fifo_full}, 32'd0);
        check("async_rst_ovf",   {31'd0, bus.overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        strobe(1'b0, 6'h00, 1'b1, 6'h2A, 12'd9);
        tick(3);
        check("post_rst_tail_ignored", {31'd0, bus.evt_valid}, 32'd0);
        strobe(1'b1, 6'h15, 1'b1, 6'h16, 12'd0);
        tick(1);
        check("post_rst_first_word", bus.evt_data, 32'h0000_0556);
        pop();
        check("post_rst_empty", {31'd0, bus.evt_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
